// File: rtl/cardinal_nic_deep_pkg.sv
// cardinal_nic_deep_pkg: shared address codes, status bit offsets and sizing helper for the Cardinal NIC
package cardinal_nic_deep_pkg;

    typedef enum logic [1:0] {
        NIC_ADDR_IN_DATA  = 2'b00,
        NIC_ADDR_IN_STAT  = 2'b01,
        NIC_ADDR_OUT_DATA = 2'b10,
        NIC_ADDR_OUT_STAT = 2'b11
    } nic_addr_e;

    // Status bit positions, counted down from the packet MSB.
    localparam int STAT_VALID_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;

    // Occupancy counters must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cardinal_nic_deep_if.sv
// cardinal_nic_deep_if: processor and router channel signals of the Cardinal NIC
interface cardinal_nic_deep_if #(parameter int PACKET_SIZE = 64);

    logic                   nicEn;
    logic                   nicWrEn;
    logic [1:0]             addr;
    logic [PACKET_SIZE-1:0] d_in;
    logic [PACKET_SIZE-1:0] d_out;
    logic                   net_si;
    logic                   net_ri;
    logic [PACKET_SIZE-1:0] net_di;
    logic                   net_so;
    logic                   net_ro;
    logic [PACKET_SIZE-1:0] net_do;
    logic                   net_polarity;

    modport master (
        output nicEn, nicWrEn, addr, d_in, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  nicEn, nicWrEn, addr, d_in, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

endinterface

// File: rtl/cardinal_nic_fifo.sv
// cardinal_nic_fifo: first-word-fall-through FIFO; full refuses pushes, empty refuses pops
module cardinal_nic_fifo
    import cardinal_nic_deep_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is never reset; stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end

endmodule

// File: rtl/cardinal_nic_deep.sv
// cardinal_nic_deep: processor-to-ring bridge with deep FIFOs, status words, sticky overflow and VC gating
module cardinal_nic_deep
    import cardinal_nic_deep_pkg::*;
#(
    parameter int PACKET_SIZE = 64,
    parameter int DEPTH       = 4,
    parameter int VC_BIT      = 0
) (
    input logic                  clk,
    input logic                  reset,
    cardinal_nic_deep_if.slave   bus
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic                   rd;
    logic                   wr;
    logic                   in_full;
    logic                   in_empty;
    logic                   out_full;
    logic                   out_empty;
    logic                   in_ovf;
    logic                   out_ovf;
    logic [CNT_W-1:0]       in_count;
    logic [CNT_W-1:0]       out_count;
    logic [PACKET_SIZE-1:0] in_head;
    logic [PACKET_SIZE-1:0] out_head;
    logic [PACKET_SIZE-1:0] in_stat;
    logic [PACKET_SIZE-1:0] out_stat;

    assign rd = bus.nicEn & ~bus.nicWrEn;
    assign wr = bus.nicEn & bus.nicWrEn;

    assign bus.net_ri = ~in_full;
    assign bus.net_so = ~out_empty & bus.net_ro & (out_head[VC_BIT] != bus.net_polarity);
    assign bus.net_do = bus.net_so ? out_head : '0;

    cardinal_nic_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.net_si),
        .pop   (rd & (bus.addr == NIC_ADDR_IN_DATA)),
        .din   (bus.net_di),
        .head  (in_head),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    cardinal_nic_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr & (bus.addr == NIC_ADDR_OUT_DATA)),
        .pop   (bus.net_so),
        .din   (bus.d_in),
        .head  (out_head),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    // Sticky overflow flags: a drop in the same cycle as a clearing status read leaves the flag set.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            in_ovf  <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            in_ovf  <= (bus.net_si & in_full) | (in_ovf & ~(rd & (bus.addr == NIC_ADDR_IN_STAT)));
            out_ovf <= (wr & (bus.addr == NIC_ADDR_OUT_DATA) & out_full) |
                       (out_ovf & ~(rd & (bus.addr == NIC_ADDR_OUT_STAT)));
        end

    // Status words: flag bits at the top, occupancy in the low bits, everything else zero.
    always_comb begin
        in_stat                              = '0;
        in_stat[PACKET_SIZE-STAT_VALID_BIT]  = ~in_empty;
        in_stat[PACKET_SIZE-STAT_OVF_BIT]    = in_ovf;
        in_stat[CNT_W-1:0]                   = in_count;
        out_stat                             = '0;
        out_stat[PACKET_SIZE-STAT_VALID_BIT] = out_full;
        out_stat[PACKET_SIZE-STAT_OVF_BIT]   = out_ovf;
        out_stat[CNT_W-1:0]                  = out_count;
    end

    // Processor read mux; an empty in-FIFO reads as zero rather than a stale entry.
    always_comb begin
        bus.d_out = !rd                            ? '0 :
                    bus.addr == NIC_ADDR_IN_DATA   ? (in_empty ? '0 : in_head) :
                    bus.addr == NIC_ADDR_IN_STAT   ? in_stat :
                    bus.addr == NIC_ADDR_OUT_STAT  ? out_stat : '0;
    end

endmodule

// File: tb/tb_cardinal_nic_deep.sv
// tb_cardinal_nic_deep: directed scenarios plus randomized traffic checked against a queue-based model
module tb_cardinal_nic_deep;

    localparam int P = 64;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [P-1:0] in_q[$];
    logic [P-1:0] out_q[$];
    bit           in_ovf;
    bit           out_ovf;

    always #5 clk = ~clk;

    cardinal_nic_deep_if #(.PACKET_SIZE(P)) bus();

    cardinal_nic_deep #(.PACKET_SIZE(P), .DEPTH(D), .VC_BIT(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] stat_word(input bit hi, input bit ovf, input int cnt);
        logic [P-1:0] w;
        w = '0;
        w[P-1] = hi;
        w[P-2] = ovf;
        w[2:0] = 3'(cnt);
        return w;
    endfunction

    function automatic bit exp_so();
        return out_q.size() > 0 && bus.net_ro && (out_q[0][0] != bus.net_polarity);
    endfunction

    function automatic logic [P-1:0] exp_dout();
        if (!(bus.nicEn && !bus.nicWrEn)) return '0;
        case (bus.addr)
            2'd0:    return in_q.size() > 0 ? in_q[0] : '0;
            2'd1:    return stat_word(in_q.size() > 0, in_ovf, in_q.size());
            2'd3:    return stat_word(out_q.size() == D, out_ovf, out_q.size());
            default: return '0;
        endcase
    endfunction

    task automatic model_clear();
        in_q.delete();
        out_q.delete();
        in_ovf = 0;
        out_ovf = 0;
    endtask

    task automatic compare();
        chk("d_out", bus.d_out, exp_dout());
        chk("net_ri", P'(bus.net_ri), P'(in_q.size() < D));
        chk("net_so", P'(bus.net_so), P'(exp_so()));
        chk("net_do", bus.net_do, exp_so() ? out_q[0] : '0);
    endtask

    task automatic model_update();
        bit rd, wr, so, in_full, out_full;
        if (reset) begin
            model_clear();
            return;
        end
        rd       = bus.nicEn && !bus.nicWrEn;
        wr       = bus.nicEn && bus.nicWrEn;
        so       = exp_so();
        in_full  = in_q.size() == D;
        out_full = out_q.size() == D;
        in_ovf   = (bus.net_si && in_full) || (in_ovf && !(rd && bus.addr == 2'd1));
        out_ovf  = (wr && bus.addr == 2'd2 && out_full) || (out_ovf && !(rd && bus.addr == 2'd3));
        if (rd && bus.addr == 2'd0 && in_q.size() > 0) void'(in_q.pop_front());
        if (bus.net_si && !in_full) in_q.push_back(bus.net_di);
        if (so) void'(out_q.pop_front());
        if (wr && bus.addr == 2'd2 && !out_full) out_q.push_back(bus.d_in);
    endtask

    task automatic drive(input bit en, input bit wr, input logic [1:0] a, input logic [P-1:0] din,
                         input bit si, input logic [P-1:0] di, input bit ro, input bit pol);
        bus.nicEn        = en;
        bus.nicWrEn      = wr;
        bus.addr         = a;
        bus.d_in         = din;
        bus.net_si       = si;
        bus.net_di       = di;
        bus.net_ro       = ro;
        bus.net_polarity = pol;
    endtask

    task automatic settle();
        @(negedge clk);
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        model_clear();
        drive(1, 0, 2'd1, '0, 0, '0, 0, 0);
        settle();
        chk("rst_ri", P'(bus.net_ri), P'(1));
        chk("rst_dout", bus.d_out, '0);
        chk("rst_so", P'(bus.net_so), '0);
        advance();
        reset = 1'b0;

        // Reset mid-stream with three packets buffered
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 2'd0, '0, 1, P'(64'h10 + k), 0, 0);
            tick();
        end
        drive(1, 0, 2'd1, '0, 0, '0, 0, 0);
        settle();
        chk("pre_rst_stat", bus.d_out, 64'h8000_0000_0000_0003);
        advance();
        reset = 1'b1;
        model_clear();
        #1;
        chk("mid_rst_ri", P'(bus.net_ri), P'(1));
        chk("mid_rst_stat", bus.d_out, '0);
        tick();
        reset = 1'b0;
        drive(1, 0, 2'd0, '0, 0, '0, 0, 0);
        settle();
        chk("post_rst_data", bus.d_out, '0);
        advance();

        // Fill the out FIFO past capacity while the router stalls
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 2'd2, P'(64'hA1 + 2 * k), 0, '0, 0, 0);
            tick();
        end
        drive(1, 0, 2'd3, '0, 0, '0, 0, 0);
        settle();
        chk("out_stat_full", bus.d_out, 64'hC000_0000_0000_0004);
        advance();
        settle();
        chk("out_stat_clr", bus.d_out, 64'h8000_0000_0000_0004);
        advance();

        // VC gating on the head packet (bit0 = 1)
        drive(0, 0, 2'd0, '0, 0, '0, 1, 1);
        settle();
        chk("vc_block", P'(bus.net_so), '0);
        advance();
        drive(0, 0, 2'd0, '0, 0, '0, 1, 0);
        settle();
        chk("vc_pass_so", P'(bus.net_so), P'(1));
        chk("vc_pass_do", bus.net_do, 64'hA1);
        advance();
        drive(1, 0, 2'd3, '0, 0, '0, 0, 0);
        settle();
        chk("vc_count", bus.d_out, 64'h3);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 2'd0, '0, 0, '0, 1, 0);
            settle();
            chk("drain_do", bus.net_do, P'(64'hA3 + 2 * k));
            advance();
        end

        // Back-to-back send of four packets
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 2'd2, P'(64'hB0 + 2 * k), 0, '0, 0, 0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 2'd0, '0, 0, '0, 1, 1);
            settle();
            chk("b2b_so", P'(bus.net_so), P'(k < 4));
            chk("b2b_do", bus.net_do, k < 4 ? P'(64'hB0 + 2 * k) : '0);
            advance();
        end

        // Router burst into the in FIFO
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 2'd0, '0, 1, P'(64'hC0 + k), 0, 0);
            settle();
            chk("burst_ri", P'(bus.net_ri), P'(k < 4));
            advance();
        end
        drive(1, 0, 2'd1, '0, 0, '0, 0, 0);
        settle();
        chk("burst_stat", bus.d_out, 64'hC000_0000_0000_0004);
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 2'd0, '0, 0, '0, 0, 0);
            settle();
            chk("burst_read", bus.d_out, k < 4 ? P'(64'hC0 + k) : '0);
            advance();
        end

        // Concurrent push and pop on the in FIFO
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 2'd0, '0, 1, P'(64'hD0 + k), 0, 0);
            tick();
        end
        drive(1, 0, 2'd0, '0, 1, 64'hD2, 0, 0);
        settle();
        chk("conc_head", bus.d_out, 64'hD0);
        advance();
        drive(1, 0, 2'd1, '0, 0, '0, 0, 0);
        settle();
        chk("conc_count", bus.d_out, 64'h8000_0000_0000_0002);
        advance();
        for (int k = 1; k < 3; k++) begin
            drive(1, 0, 2'd0, '0, 0, '0, 0, 0);
            settle();
            chk("conc_order", bus.d_out, P'(64'hD0 + k));
            advance();
        end
        drive(1, 0, 2'd0, '0, 1, 64'hE0, 0, 0);
        settle();
        chk("empty_pushread", bus.d_out, '0);
        advance();
        drive(1, 0, 2'd1, '0, 0, '0, 0, 0);
        settle();
        chk("empty_count", bus.d_out, 64'h8000_0000_0000_0001);
        advance();
        drive(1, 0, 2'd0, '0, 0, '0, 0, 0);
        settle();
        chk("empty_after", bus.d_out, 64'hE0);
        advance();

        // Randomized traffic with phase-varying pressure and occasional async resets
        begin
            int si_pct, ro_pct;
            bit pol;
            pol = 0;
            si_pct = 50;
            ro_pct = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 200 == 0) begin
                    si_pct = $urandom_range(10, 90);
                    ro_pct = $urandom_range(10, 90);
                end
                if ($urandom_range(0, 7) == 0) pol = ~pol;
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                      {$urandom, $urandom}, $urandom_range(0, 99) < si_pct, {$urandom, $urandom},
                      $urandom_range(0, 99) < ro_pct, pol);
                if ($urandom_range(0, 299) == 0) begin
                    reset = 1'b1;
                    model_clear();
                end
                tick();
                reset = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
